// File: rtl/gemm_tile_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gemm_tile_sequencer_pkg
// Description : Shared definitions for the gemm tile sequencer: systolic
//               array dimensions, gemm register map, sequencer state
//               encoding, the packed tile-size word, and a tile-size helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gemm_tile_sequencer_pkg;

    // Systolic array geometry; sets the default B/C tile width and tile depth.
    localparam int SUPER_SYS_ROWS = 16;
    localparam int SUPER_SYS_COLS = 16;

    // Width of each tile-size field in the DIM register.
    localparam int SIZE_W = 5;

    // gemm register offsets from the gemm base address. Reads of REG_A
    // return FULL status; reads of REG_DIM return DONE status.
    localparam logic [31:0] REG_A    = 32'd0;
    localparam logic [31:0] REG_B    = 32'd4;
    localparam logic [31:0] REG_C    = 32'd8;
    localparam logic [31:0] REG_ASTR = 32'd12;
    localparam logic [31:0] REG_BSTR = 32'd16;
    localparam logic [31:0] REG_CTRL = 32'd20;
    localparam logic [31:0] REG_DIM  = 32'd24;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_ASTR  = 4'd1,
        WR_BSTR  = 4'd2,
        WR_A     = 4'd3,
        WR_B     = 4'd4,
        WR_C     = 4'd5,
        WR_CTRL  = 4'd6,
        WR_DIM   = 4'd7,
        RD_FULL  = 4'd8,
        CHK_FULL = 4'd9,
        RD_DONE  = 4'd10,
        CHK_DONE = 4'd11
    } seq_state_t;

    typedef struct packed {
        logic [SIZE_W-1:0] nsize;
        logic [SIZE_W-1:0] ksize;
        logic [SIZE_W-1:0] msize;
    } gemm_dim_t;

    // Size of a tile given the remaining extent and the tile block size.
    function automatic logic [SIZE_W-1:0] tile_size(input logic [31:0] remain,
                                                    input logic [31:0] blk);
        logic [31:0] v;
        v = (remain < blk) ? remain : blk;
        return SIZE_W'(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gemm_tile_sequencer_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : gemm_tile_addr_gen
// Description : Combinational per-tile address and size generation from the
//               latched GEMM job and the current n/m/k tile origin.
// Ports       : dim_m/k/n       - latched matrix dimensions
//               a/b/c_base      - latched element base addresses
//               m/k/n_idx       - current tile origin
//               a/b/c_addr      - tile start addresses (B: last tile row)
//               ctrl_word       - {30'b0, first, last}
//               dim_word        - packed msize/ksize/nsize
//               last_k/m/n      - current tile is the last along that loop
// Revision    : 1.0 - initial release
// ============================================================================
module gemm_tile_addr_gen
    import gemm_tile_sequencer_pkg::*;
#(
    parameter int BLKM  = 16,
    parameter int BLKN  = SUPER_SYS_ROWS,
    parameter int BLKK  = SUPER_SYS_COLS,
    parameter int DIM_W = 16
) (
    input  logic [DIM_W-1:0] dim_m,
    input  logic [DIM_W-1:0] dim_k,
    input  logic [DIM_W-1:0] dim_n,
    input  logic [31:0]      a_base,
    input  logic [31:0]      b_base,
    input  logic [31:0]      c_base,
    input  logic [DIM_W-1:0] m_idx,
    input  logic [DIM_W-1:0] k_idx,
    input  logic [DIM_W-1:0] n_idx,
    output logic [31:0]      a_addr,
    output logic [31:0]      b_addr,
    output logic [31:0]      c_addr,
    output logic [31:0]      ctrl_word,
    output logic [31:0]      dim_word,
    output logic             last_k,
    output logic             last_m,
    output logic             last_n
);

    localparam logic [31:0] c_blkm = 32'(BLKM);
    localparam logic [31:0] c_blkn = 32'(BLKN);
    localparam logic [31:0] c_blkk = 32'(BLKK);

    // All arithmetic is carried out in 32 bits and wraps modulo 2^32.
    logic [31:0] w_dm, w_dk, w_dn;
    logic [31:0] w_m, w_k, w_n;
    gemm_dim_t   w_dim;
    logic        w_first;

    assign w_dm = 32'(dim_m);
    assign w_dk = 32'(dim_k);
    assign w_dn = 32'(dim_n);
    assign w_m  = 32'(m_idx);
    assign w_k  = 32'(k_idx);
    assign w_n  = 32'(n_idx);

    assign w_dim.msize = tile_size(w_dm - w_m, c_blkm);
    assign w_dim.ksize = tile_size(w_dk - w_k, c_blkk);
    assign w_dim.nsize = tile_size(w_dn - w_n, c_blkn);

    assign a_addr = a_base + w_k + (w_m * w_dk);
    // B is streamed bottom-up, so point at the last row of the B tile.
    assign b_addr = b_base + w_n + ((w_k + 32'(w_dim.ksize) - 32'd1) * w_dn);
    assign c_addr = c_base + w_n + (w_m * w_dn);

    assign last_k  = (w_k + c_blkk) >= w_dk;
    assign last_m  = (w_m + c_blkm) >= w_dm;
    assign last_n  = (w_n + c_blkn) >= w_dn;
    assign w_first = (k_idx == '0);

    assign ctrl_word = {30'd0, w_first, last_k};
    assign dim_word  = {{(32-$bits(gemm_dim_t)){1'b0}}, w_dim};

endmodule
`default_nettype wire

// File: rtl/gemm_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gemm_tile_sequencer
// Description : Walks the n/m/k tile loops of a whole GEMM job, issuing the
//               per-tile gemm register writes over the system bus and
//               polling the gemm FULL and DONE status.
// Ports       : clk, rst (async, active-high)
//               start, cfg_m/k/n, cfg_a/b/c_addr - job request
//               busy, done, err                  - job status
//               bus_en, bus_rdwr, bus_addr,
//               bus_wr_data, bus_rd_data         - gemm system bus master
//               perf_cycles, perf_tiles          - only with
//                                                  GEMM_SEQ_PERF_CNT_EN
// Options     : `define GEMM_SEQ_PERF_CNT_EN to add performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module gemm_tile_sequencer
    import gemm_tile_sequencer_pkg::*;
#(
    parameter int          BLKM      = 16,
    parameter int          BLKN      = SUPER_SYS_ROWS,
    parameter int          BLKK      = SUPER_SYS_COLS,
    parameter int          DIM_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h9000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] cfg_m,
    input  logic [DIM_W-1:0] cfg_k,
    input  logic [DIM_W-1:0] cfg_n,
    input  logic [31:0]      cfg_a_addr,
    input  logic [31:0]      cfg_b_addr,
    input  logic [31:0]      cfg_c_addr,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             bus_en,
    output logic             bus_rdwr,
    output logic [31:0]      bus_addr,
    output logic [31:0]      bus_wr_data,
    input  logic [31:0]      bus_rd_data
`ifdef GEMM_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_tiles
`endif
);

    seq_state_t       r_state;
    seq_state_t       w_state_next;

    logic [DIM_W-1:0] r_dim_m, r_dim_k, r_dim_n;
    logic [DIM_W-1:0] r_m_idx, r_k_idx, r_n_idx;
    logic [31:0]      r_a_base, r_b_base, r_c_base;
    logic             r_done, r_err;

    logic             w_start_ok;
    logic             w_zero_dim;
    logic             w_rd_one;
    logic             w_advance;
    logic [31:0]      w_a_addr, w_b_addr, w_c_addr, w_ctrl, w_dim;
    logic             w_last_k, w_last_m, w_last_n;

    assign w_start_ok = (r_state == IDLE) && start;
    assign w_zero_dim = (cfg_m == '0) || (cfg_k == '0) || (cfg_n == '0);
    assign w_rd_one   = (bus_rd_data == 32'd1);
    // A CHK_FULL cycle that does not see FULL moves on to the next tile.
    assign w_advance  = (r_state == CHK_FULL) && !w_rd_one;

    gemm_tile_addr_gen #(
        .BLKM  (BLKM),
        .BLKN  (BLKN),
        .BLKK  (BLKK),
        .DIM_W (DIM_W)
    ) u_addr_gen (
        .dim_m     (r_dim_m),
        .dim_k     (r_dim_k),
        .dim_n     (r_dim_n),
        .a_base    (r_a_base),
        .b_base    (r_b_base),
        .c_base    (r_c_base),
        .m_idx     (r_m_idx),
        .k_idx     (r_k_idx),
        .n_idx     (r_n_idx),
        .a_addr    (w_a_addr),
        .b_addr    (w_b_addr),
        .c_addr    (w_c_addr),
        .ctrl_word (w_ctrl),
        .dim_word  (w_dim),
        .last_k    (w_last_k),
        .last_m    (w_last_m),
        .last_n    (w_last_n)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:     if (w_start_ok && !w_zero_dim) w_state_next = WR_ASTR;
            WR_ASTR:  w_state_next = WR_BSTR;
            WR_BSTR:  w_state_next = WR_A;
            WR_A:     w_state_next = WR_B;
            WR_B:     w_state_next = WR_C;
            WR_C:     w_state_next = WR_CTRL;
            WR_CTRL:  w_state_next = WR_DIM;
            WR_DIM:   w_state_next = RD_FULL;
            RD_FULL:  w_state_next = CHK_FULL;
            CHK_FULL: begin
                if (w_rd_one) begin
                    w_state_next = RD_FULL;
                end else if (w_last_k && w_last_m && w_last_n) begin
                    w_state_next = RD_DONE;
                end else begin
                    w_state_next = WR_A;
                end
            end
            RD_DONE:  w_state_next = CHK_DONE;
            CHK_DONE: w_state_next = w_rd_one ? IDLE : RD_DONE;
            default:  w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus_en      = 1'b0;
        bus_rdwr    = 1'b0;
        bus_addr    = 32'd0;
        bus_wr_data = 32'd0;
        unique case (r_state)
            WR_ASTR: begin
                bus_en = 1'b1; bus_rdwr = 1'b1;
                bus_addr = BASE_ADDR + REG_ASTR; bus_wr_data = 32'(r_dim_k);
            end
            WR_BSTR: begin
                bus_en = 1'b1; bus_rdwr = 1'b1;
                bus_addr = BASE_ADDR + REG_BSTR; bus_wr_data = 32'(r_dim_n);
            end
            WR_A: begin
                bus_en = 1'b1; bus_rdwr = 1'b1;
                bus_addr = BASE_ADDR + REG_A; bus_wr_data = w_a_addr;
            end
            WR_B: begin
                bus_en = 1'b1; bus_rdwr = 1'b1;
                bus_addr = BASE_ADDR + REG_B; bus_wr_data = w_b_addr;
            end
            WR_C: begin
                bus_en = 1'b1; bus_rdwr = 1'b1;
                bus_addr = BASE_ADDR + REG_C; bus_wr_data = w_c_addr;
            end
            WR_CTRL: begin
                bus_en = 1'b1; bus_rdwr = 1'b1;
                bus_addr = BASE_ADDR + REG_CTRL; bus_wr_data = w_ctrl;
            end
            WR_DIM: begin
                bus_en = 1'b1; bus_rdwr = 1'b1;
                bus_addr = BASE_ADDR + REG_DIM; bus_wr_data = w_dim;
            end
            // The read request is held through the CHK cycle while the
            // returned status is sampled.
            RD_FULL, CHK_FULL: begin
                bus_en = 1'b1; bus_addr = BASE_ADDR + REG_A;
            end
            RD_DONE, CHK_DONE: begin
                bus_en = 1'b1; bus_addr = BASE_ADDR + REG_DIM;
            end
            default: ;
        endcase
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign err  = r_err;

    // ------------------------------------------------------------------
    // Job latch, loop counters and status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dim_m  <= '0;
            r_dim_k  <= '0;
            r_dim_n  <= '0;
            r_a_base <= '0;
            r_b_base <= '0;
            r_c_base <= '0;
            r_m_idx  <= '0;
            r_k_idx  <= '0;
            r_n_idx  <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= (r_state == CHK_DONE) && w_rd_one;
            r_err  <= w_start_ok && w_zero_dim;
            if (w_start_ok) begin
                r_dim_m  <= cfg_m;
                r_dim_k  <= cfg_k;
                r_dim_n  <= cfg_n;
                r_a_base <= cfg_a_addr;
                r_b_base <= cfg_b_addr;
                r_c_base <= cfg_c_addr;
                r_m_idx  <= '0;
                r_k_idx  <= '0;
                r_n_idx  <= '0;
            end else if (w_advance) begin
                // k innermost, then m, with n outermost.
                if (!w_last_k) begin
                    r_k_idx <= r_k_idx + DIM_W'(BLKK);
                end else begin
                    r_k_idx <= '0;
                    if (!w_last_m) begin
                        r_m_idx <= r_m_idx + DIM_W'(BLKM);
                    end else begin
                        r_m_idx <= '0;
                        if (!w_last_n) begin
                            r_n_idx <= r_n_idx + DIM_W'(BLKN);
                        end
                    end
                end
            end
        end
    end

`ifdef GEMM_SEQ_PERF_CNT_EN
    // perf_cycles counts the start cycle, every busy cycle and the done cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= 32'd0;
            perf_tiles  <= 32'd0;
        end else if (w_start_ok) begin
            perf_cycles <= w_zero_dim ? 32'd0 : 32'd1;
            perf_tiles  <= 32'd0;
        end else begin
            if (busy || r_done) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if (r_state == WR_DIM) begin
                perf_tiles <= perf_tiles + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gemm_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gemm_tile_sequencer
// Description : Self-checking bench for gemm_tile_sequencer. A bus-slave
//               model answers FULL/DONE polls; a loop-nest reference model
//               builds the expected write stream of each job.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gemm_tile_sequencer;

    localparam logic [31:0] BASE = 32'h9000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cfg_m = '0, cfg_k = '0, cfg_n = '0;
    logic [31:0] cfg_a_addr = '0, cfg_b_addr = '0, cfg_c_addr = '0;
    logic        busy, done, err, bus_en, bus_rdwr;
    logic [31:0] bus_addr, bus_wr_data;
    logic [31:0] bus_rd_data = '0;

    gemm_tile_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_m       (cfg_m),
        .cfg_k       (cfg_k),
        .cfg_n       (cfg_n),
        .cfg_a_addr  (cfg_a_addr),
        .cfg_b_addr  (cfg_b_addr),
        .cfg_c_addr  (cfg_c_addr),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .bus_en      (bus_en),
        .bus_rdwr    (bus_rdwr),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor-owned (monotonic) state.
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int rd_run = 0, tiles_seen = 0, stall_used = 0, done_polls = 0;
    int done_cnt = 0, err_cnt = 0, bus_cnt = 0, busy_cnt = 0;

    // Stimulus-owned job configuration and snapshots.
    int q_base = 0, tile_base = 0, stall_base = 0, done_base = 0, done_cnt_base = 0;
    int stall_tile = -1, stall_cnt = 0, done_dly = 0, rand_full = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    function automatic logic [31:0] not_one();
        logic [31:0] v;
        v = $urandom;
        if (v == 32'd1) v = 32'd0;
        return v;
    endfunction

    // Bus slave: records writes; answers each newly issued read. Reads come
    // in RD/CHK pairs, so even positions within a run of read cycles are
    // fresh requests and odd positions are the held request.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (bus_en) bus_cnt++;
        if (busy) busy_cnt++;
        if (rst || !bus_en) begin
            rd_run = 0;
        end else if (bus_rdwr) begin
            wr_addr_q.push_back(bus_addr);
            wr_data_q.push_back(bus_wr_data);
            wr_cyc_q.push_back(cyc);
            if (bus_addr == BASE + 32'd24) tiles_seen++;
            rd_run = 0;
        end else begin
            if (rd_run % 2 == 0) begin
                if (bus_addr == BASE) begin
                    if ((tiles_seen - tile_base == stall_tile) && (stall_used - stall_base < stall_cnt)) begin
                        bus_rd_data = 32'd1;
                        stall_used++;
                    end else if (rand_full != 0 && $urandom_range(0, 3) == 0) begin
                        bus_rd_data = 32'd1;
                    end else begin
                        bus_rd_data = not_one();
                    end
                end else begin
                    if (done_polls - done_base < done_dly) begin
                        bus_rd_data = not_one();
                        done_polls++;
                    end else begin
                        bus_rd_data = 32'd1;
                    end
                end
            end
            rd_run++;
        end
    end

    // Reference model: expected write stream straight from the loop nest.
    task automatic build_expected(input int md, kd, nd, input logic [31:0] a, b, c);
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_addr_q.push_back(BASE + 32'd12); exp_data_q.push_back(32'(kd));
        exp_addr_q.push_back(BASE + 32'd16); exp_data_q.push_back(32'(nd));
        for (int n = 0; n < nd; n += 16) begin
            for (int m = 0; m < md; m += 16) begin
                for (int k = 0; k < kd; k += 16) begin
                    int ms, ks, ns;
                    ms = (md - m < 16) ? md - m : 16;
                    ks = (kd - k < 16) ? kd - k : 16;
                    ns = (nd - n < 16) ? nd - n : 16;
                    exp_addr_q.push_back(BASE);
                    exp_data_q.push_back(a + 32'(k) + 32'(m) * 32'(kd));
                    exp_addr_q.push_back(BASE + 32'd4);
                    exp_data_q.push_back(b + 32'(n) + 32'(k + ks - 1) * 32'(nd));
                    exp_addr_q.push_back(BASE + 32'd8);
                    exp_data_q.push_back(c + 32'(n) + 32'(m) * 32'(nd));
                    exp_addr_q.push_back(BASE + 32'd20);
                    exp_data_q.push_back({30'd0, (k == 0), (k + 16 >= kd)});
                    exp_addr_q.push_back(BASE + 32'd24);
                    exp_data_q.push_back(32'(ms) | (32'(ks) << 5) | (32'(ns) << 10));
                end
            end
        end
    endtask

    task automatic launch(input int md, kd, nd, input logic [31:0] a, b, c,
                          input int s_tile, s_cnt, d_dly, r_full);
        @(posedge clk); #1;
        q_base        = wr_addr_q.size();
        tile_base     = tiles_seen;
        stall_base    = stall_used;
        done_base     = done_polls;
        done_cnt_base = done_cnt;
        stall_tile    = s_tile;
        stall_cnt     = s_cnt;
        done_dly      = d_dly;
        rand_full     = r_full;
        cfg_m = 16'(md); cfg_k = 16'(kd); cfg_n = 16'(nd);
        cfg_a_addr = a; cfg_b_addr = b; cfg_c_addr = c;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int got;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (got == 0) begin
            errors++;
            $display("FAIL %s done: no done pulse within %0d cycles, required one", name, budget);
        end else begin
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL %s busy at done: got %b required 0", name, busy);
            end
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (done_cnt - done_cnt_base !== 1) begin
            errors++;
            $display("FAIL %s done pulse count: got %0d required 1", name, done_cnt - done_cnt_base);
        end
    endtask

    task automatic compare_writes(input string name);
        int n_act, bad, lim;
        n_act = wr_addr_q.size() - q_base;
        checks++;
        if (n_act != exp_addr_q.size()) begin
            errors++;
            $display("FAIL %s write count: got %0d required %0d", name, n_act, exp_addr_q.size());
        end
        lim = (n_act < exp_addr_q.size()) ? n_act : exp_addr_q.size();
        bad = -1;
        for (int i = 0; i < lim; i++) begin
            if (wr_addr_q[q_base + i] !== exp_addr_q[i] || wr_data_q[q_base + i] !== exp_data_q[i]) begin
                bad = i;
                break;
            end
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s write %0d: got addr %h data %h required addr %h data %h", name, bad,
                     wr_addr_q[q_base + bad], wr_data_q[q_base + bad], exp_addr_q[bad], exp_data_q[bad]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, bus_en, bus_rdwr} !== 5'b0) begin
            errors++;
            $display("FAIL reset flags: got %b required 00000", {busy, done, err, bus_en, bus_rdwr});
        end
        checks++;
        if (bus_addr !== 32'd0 || bus_wr_data !== 32'd0) begin
            errors++;
            $display("FAIL reset bus: got addr %h data %h required 0 0", bus_addr, bus_wr_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_tile();
        logic [31:0] t_off[7];
        logic [31:0] t_dat[7];
        t_off = '{32'd12, 32'd16, 32'd0, 32'd4, 32'd8, 32'd20, 32'd24};
        t_dat = '{32'd16, 32'd16, 32'd0, 32'd496, 32'd512, 32'd3, 32'd16912};
        build_expected(16, 16, 16, 32'd0, 32'd256, 32'd512);
        launch(16, 16, 16, 32'd0, 32'd256, 32'd512, -1, 0, 2, 0);
        wait_done("single", 400);
        compare_writes("single");
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (wr_addr_q.size() <= q_base + i) begin
                errors++;
                $display("FAIL single write %0d: missing, required %h=%0d", i, t_off[i], t_dat[i]);
            end else if (wr_addr_q[q_base + i] !== BASE + t_off[i] || wr_data_q[q_base + i] !== t_dat[i]) begin
                errors++;
                $display("FAIL single write %0d: got %h=%0d required %h=%0d", i,
                         wr_addr_q[q_base + i], wr_data_q[q_base + i], BASE + t_off[i], t_dat[i]);
            end
        end
    endtask

    task automatic test_partial_tiles();
        int last, idx;
        build_expected(20, 20, 20, 32'h100, 32'h2000, 32'h30000);
        launch(20, 20, 20, 32'h100, 32'h2000, 32'h30000, -1, 0, 0, 0);
        wait_done("partial", 800);
        compare_writes("partial");
        checks++;
        if (tiles_seen - tile_base !== 8) begin
            errors++;
            $display("FAIL partial tile count: got %0d required 8", tiles_seen - tile_base);
        end
        last = wr_data_q.size() - 1;
        checks++;
        if (last < q_base + 1 || wr_data_q[last] !== 32'd4228 || wr_data_q[last - 1] !== 32'd1) begin
            errors++;
            $display("FAIL partial final tile: got dim %0d ctrl %0d required 4228 1",
                     wr_data_q[last], wr_data_q[last - 1]);
        end
        for (int t = 0; t < 8; t += 2) begin
            idx = q_base + 2 + 5 * t + 3;
            checks++;
            if (idx >= wr_data_q.size() || wr_data_q[idx] !== 32'd2) begin
                errors++;
                $display("FAIL partial ctrl tile %0d: got %0d required 2", t,
                         (idx < wr_data_q.size()) ? wr_data_q[idx] : 32'hx);
            end
        end
    endtask

    task automatic test_backpressure();
        int gap1, gap2;
        build_expected(32, 32, 32, 32'h1000, 32'h5000, 32'h9000);
        launch(32, 32, 32, 32'h1000, 32'h5000, 32'h9000, 1, 5, 1, 0);
        wait_done("backpressure", 1500);
        compare_writes("backpressure");
        checks++;
        if (wr_cyc_q.size() < q_base + 13) begin
            errors++;
            $display("FAIL backpressure gap: too few writes %0d required at least 13", wr_cyc_q.size() - q_base);
        end else begin
            gap1 = wr_cyc_q[q_base + 7] - wr_cyc_q[q_base + 6];
            gap2 = wr_cyc_q[q_base + 12] - wr_cyc_q[q_base + 11];
            if (gap1 !== 13) begin
                errors++;
                $display("FAIL backpressure stalled gap: got %0d required 13", gap1);
            end
            checks++;
            if (gap2 !== 3) begin
                errors++;
                $display("FAIL backpressure free gap: got %0d required 3", gap2);
            end
        end
    endtask

    task automatic test_zero_dim();
        int e0, b0, y0;
        for (int w = 0; w < 3; w++) begin
            @(posedge clk); #1;
            e0 = err_cnt; b0 = bus_cnt; y0 = busy_cnt;
            cfg_m = (w == 0) ? 16'd0 : 16'd16;
            cfg_k = (w == 1) ? 16'd0 : 16'd16;
            cfg_n = (w == 2) ? 16'd0 : 16'd16;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL zero_dim %0d pulse: got err %b busy %b required 1 0", w, err, busy);
            end
            @(posedge clk); #1;
            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL zero_dim %0d err width: got %b required 0", w, err);
            end
            repeat (4) @(posedge clk);
            #1;
            checks++;
            if (bus_cnt != b0 || busy_cnt != y0 || err_cnt - e0 != 1) begin
                errors++;
                $display("FAIL zero_dim %0d activity: got bus %0d busy %0d err %0d required 0 0 1",
                         w, bus_cnt - b0, busy_cnt - y0, err_cnt - e0);
            end
        end
    endtask

    task automatic test_reset_midjob();
        int c8, hit;
        c8 = 0; hit = 0;
        launch(32, 32, 32, 32'h40, 32'h80, 32'hC0, -1, 0, 0, 0);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus_en && bus_rdwr && bus_addr == BASE + 32'd8) begin
                c8++;
                if (c8 == 3) begin
                    hit = 1;
                    break;
                end
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (hit == 0 || bus_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_midjob abort: got reached %0d bus_en %b busy %b required 1 0 0", hit, bus_en, busy);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        build_expected(32, 32, 32, 32'h40, 32'h80, 32'hC0);
        launch(32, 32, 32, 32'h40, 32'h80, 32'hC0, -1, 0, 0, 0);
        wait_done("reset_replay", 1000);
        compare_writes("reset_replay");
        checks++;
        if (wr_addr_q.size() <= q_base || wr_addr_q[q_base] !== BASE + 32'd12) begin
            errors++;
            $display("FAIL reset_replay first write: got %h required %h",
                     (wr_addr_q.size() > q_base) ? wr_addr_q[q_base] : 32'hx, BASE + 32'd12);
        end
    endtask

    task automatic test_start_while_busy();
        logic prev_rd;
        int found;
        prev_rd = 1'b0; found = 0;
        build_expected(16, 48, 16, 32'h7000, 32'h8000, 32'hA000);
        launch(16, 48, 16, 32'h7000, 32'h8000, 32'hA000, -1, 0, 1, 0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_en && !bus_rdwr && bus_addr == BASE && !prev_rd) begin
                found = 1;
                cfg_m = 16'd1; cfg_k = 16'd1; cfg_n = 16'd1;
                cfg_a_addr = 32'hDEAD_0000;
                start = 1'b1;
                break;
            end
            prev_rd = bus_en && !bus_rdwr;
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (found == 0) begin
            errors++;
            $display("FAIL start_busy: RD_FULL not reached, got 0 required 1");
        end
        wait_done("start_busy", 800);
        compare_writes("start_busy");
    endtask

    task automatic test_random();
        int md, kd, nd, dd;
        logic [31:0] a, b, c;
        for (int j = 0; j < 6; j++) begin
            md = $urandom_range(1, 40);
            kd = $urandom_range(1, 40);
            nd = $urandom_range(1, 40);
            dd = $urandom_range(0, 3);
            a = $urandom; b = $urandom; c = $urandom;
            build_expected(md, kd, nd, a, b, c);
            launch(md, kd, nd, a, b, c, -1, 0, dd, 1);
            wait_done($sformatf("random%0d", j), 4000);
            compare_writes($sformatf("random%0d", j));
        end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_partial_tiles();
        test_backpressure();
        test_zero_dim();
        test_reset_midjob();
        test_start_while_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gemm_tile_sequencer.md
Name: gemm_tile_sequencer

Overview:
Hardware tile scheduler that sits directly upstream of the gemm block's system-bus slave port.
- Takes a whole-GEMM job (M, K, N, base addresses of A, B and C) and walks the n/m/k tile loops.
- Issues the per-tile configuration writes and polls the gemm FULL and DONE status registers.
- Replaces the CPU-driven tiling loop, so the host issues one start per GEMM.

Parameters:
- BLKM, 16, tile rows of A/C.
- BLKN, SUPER_SYS_ROWS, tile cols of B/C.
- BLKK, SUPER_SYS_COLS, tile depth.
- DIM_W, 16, width of the M/K/N inputs.
- BASE_ADDR, 32'h9000_0000, gemm register base.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- start  in  1  one-cycle job start pulse; sampled only in IDLE.
- cfg_m, cfg_k, cfg_n  in  DIM_W each  matrix dimensions.
- cfg_a_addr, cfg_b_addr, cfg_c_addr  in  32 each  element base addresses.
- busy  out  1  high from the cycle after an accepted start until done/err.
- done  out  1  one-cycle pulse when the gemm reports completion.
- err  out  1  one-cycle pulse when a zero dimension is rejected.
- bus_en, bus_rdwr  out  1 each  gemm system bus enable; rdwr 1=write, 0=read.
- bus_addr, bus_wr_data  out  32 each  gemm system bus address and write data.
- bus_rd_data  in  32  gemm read data, valid the cycle after a read is issued.

Behaviour:
Reset values:
- All outputs 0; state IDLE; loop counters 0.
- Reset mid-job aborts immediately; bus_en drops in the same cycle; no partial tile is resumed.

Accepting a job:
- On start in IDLE, all cfg_* inputs are latched.
- If any of M, K, N is 0: err pulses next cycle, no bus traffic, remain IDLE.
- start while busy is ignored.

FSM: IDLE -> WR_ASTR -> WR_BSTR -> {WR_A -> WR_B -> WR_C -> WR_CTRL -> WR_DIM -> RD_FULL -> CHK_FULL} per tile -> RD_DONE -> CHK_DONE -> IDLE.
- Each WR_* state lasts 1 cycle with bus_en=1, bus_rdwr=1.
- RD_* states drive bus_en=1, bus_rdwr=0. CHK_* states hold the read request and sample bus_rd_data.
- Strides are written once per job: WR_ASTR (+12) = K, WR_BSTR (+16) = N.

Per-tile writes (addresses relative to BASE_ADDR):
- +0: A_addr + k + m*K.
- +4: B_addr + n + (k+ksize-1)*N. This is the last row of the B tile; B is streamed bottom-up.
- +8: C_addr + n + m*N.
- +20: {30'b0, first, last}, where first = (k==0) and last = (k+BLKK>=K).
- +24: msize | ksize<<5 | nsize<<10.

Tile sizes:
- msize = min(BLKM, M-m); ksize = min(BLKK, K-k); nsize = min(BLKN, N-n).
- Each size occupies a 5-bit field.

Status polling:
- CHK_FULL: rd_data==1 -> back to RD_FULL and re-poll. Otherwise advance the loop (k innermost, then m, then n, with n outermost) and go to WR_A, or to RD_DONE after the final tile.
- CHK_DONE: rd_data==1 -> done pulse, go to IDLE. Otherwise re-poll RD_DONE (+24).

Arithmetic:
- All address math is unsigned 32-bit and wraps modulo 2^32.
- Products are computed in 32-bit.
- No tile counter overflow is possible for DIM_W≤16.

Optional Feature:
GEMM_SEQ_PERF_CNT_EN
- Defined: adds outputs perf_cycles[31:0] (cycles from accepted start to done, inclusive) and perf_tiles[31:0] (tiles issued). Both clear on start and hold after done.
- Undefined: these ports and their counters are absent.

Decomposition:
- Config package gains: typedef enum for the FSM states; localparams for register offsets (REG_A=0, REG_B=4, REG_C=8, REG_ASTR=12, REG_BSTR=16, REG_CTRL=20, REG_DIM=24); a packed struct gemm_dim_t {nsize, ksize, msize}.
- One sub-module, gemm_tile_addr_gen: combinational tile address and size computation from the latched job and the current n/m/k counters.

Test Plan:
- M=K=N=16, A=0, B=256, C=512, gemm status never full: writes are +12=16, +16=16, +0=0, +4=496, +8=512, +20=3, +24=16912. Then done pulses once rd_data(+24)=1.
- M=K=N=20: exactly 8 tiles issued. The final tile has DIM=4228 and CTRL=1. The k=0 tiles have CTRL=2.
- Full back-pressure, M=K=N=32: the bench returns rd_data=1 for 5 consecutive +0 polls after tile 1. WR_A of tile 2 is delayed exactly 5 poll cycles. Tile values are unchanged.
- cfg_k=0 with start: err pulses one cycle later, bus_en never asserts, busy stays 0.
- Reset asserted during WR_C of tile 3: bus_en is 0 combinationally with rst. A new start afterwards replays from tile 1 with +12 first.
- Start pulsed during RD_FULL: ignored; the job finishes with an unchanged write count.
